spi_word_tx: RTL

SPI-mode-0 master transmitter for the LnL SoC. It shifts 16-bit accumulator words, written by the CPU OUT path, onto sck/mosi/cs_n. It is the sending-end counterpart of the SoC's spin/spcsin serial receive port, so two SoCs, or a SoC and a host, can be chained. It sits beside the display/keyboard I/O logic, and tx_ready serves as the CPU output flag (FGO).

---
 rtl/lnl_spi_pkg.sv | 16 +
 rtl/spi_tick_gen.sv | 35 +++
 rtl/spi_word_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lnl_spi_pkg.sv
// Shared SPI definitions for the LnL SoC serial transmit/receive ports.
// Holds the frame FSM states, bus mode constants and the default word width.
package lnl_spi_pkg;

    localparam int   SPI_DATA_W = 16;
    localparam logic SPI_CPOL   = 1'b0;
    localparam logic SPI_CPHA   = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP
    } spi_tx_state_e;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer for the SPI transmitter: tick is high on the last clk
// cycle of every CLK_DIV-cycle half-period; clear restarts the count.
module spi_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W    = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/spi_word_tx.sv
// SPI mode-0 master transmitter: shifts one DATA_W word per frame, MSB first,
// with a trailing hold half-period and an inter-frame gap before tx_ready returns.
module spi_word_tx
    import lnl_spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              sck,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done
);

    localparam int               BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    spi_tx_state_e     state_q, state_d;
    // Bits still to send below the one currently on mosi.
    logic [DATA_W-2:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic accept;
    logic tick;

    assign accept = tx_valid && tx_ready_q;

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = SHIFT;
                    shreg_d    = tx_data[DATA_W-2:0];
                    mosi_d     = tx_data[DATA_W-1];
                    bit_cnt_d  = '0;
                    sck_d      = SPI_CPOL;
                    cs_n_d     = 1'b0;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        // The last bit stays on mosi through HOLD.
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = HOLD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            mosi_d    = shreg_q[DATA_W-2];
                            shreg_d   = {shreg_q[DATA_W-3:0], 1'b0};
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d   = GAP;
                    cs_n_d    = 1'b1;
                    mosi_d    = 1'b0;
                    done_d    = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d    = IDLE;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            sck_q      <= SPI_CPOL;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
